accum_rmw_ctrl: RTL and testbench

Read-modify-write controller sitting directly upstream of the BRAM accumulator: takes per-cycle partial-sum vectors from the compute array, reads the stored running sum, adds lane-wise with signed saturation, and writes the result back. One operation per cycle with no stalls, including back-to-back hits on the same address. It also provides a full-memory clear sequence and emits the final sums on a last-pass flag.

---
 rtl/accum_rmw_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_accum_rmw_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_rmw_ctrl.sv
// rtl/accum_rmw_ctrl.sv - lane-wise saturating read-modify-write controller for the BRAM accumulator
module accum_rmw_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64,
   parameter int LANE_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_first,
   input  logic                  i_last,
   input  logic                  i_clear,
   output logic                  o_ready,
   output logic                  o_rd_en,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [DATA_WIDTH-1:0] o_wr_data,
   output logic                  o_out_valid,
   output logic [ADDR_WIDTH-1:0] o_out_addr,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic                  o_busy
);

   localparam int LANES = DATA_WIDTH / LANE_WIDTH;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t state, next_state;
   logic   flush_done;

   // S1: operation captured in the issue cycle, computed while its read returns
   logic                  s1_valid;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [DATA_WIDTH-1:0] s1_data;
   logic                  s1_first;
   logic                  s1_last;

   // S2 op flag: o_wr_en also carries clear writes, which must never be forwarded
   logic                  s2_valid;

   // S3: the write that hit the RAM last cycle; a read issued on that same edge saw stale data
   logic                  s3_valid;
   logic [ADDR_WIDTH-1:0] s3_addr;
   logic [DATA_WIDTH-1:0] s3_data;

   logic [DATA_WIDTH-1:0] old_data;
   logic [DATA_WIDTH-1:0] sum_data;
   logic [ADDR_WIDTH-1:0] clr_addr_next;

   assign o_ready   = (state == RUN);
   assign o_rd_en   = i_valid & o_ready;
   assign o_rd_addr = i_addr;
   assign o_busy    = (state != RUN) | s1_valid | s2_valid;

   // clear writes walk the address space using the write-address register itself as the counter
   assign clr_addr_next = (state == CLEAR) ? o_wr_addr + ADDR_WIDTH'(1) : '0;

   // state register; flush_done marks the second FLUSH cycle, by which time the last accepted op has left S1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         flush_done <= 1'b0;
      end else begin
         state      <= next_state;
         flush_done <= (state == FLUSH);
      end
   end

   // next-state: RUN -> FLUSH on clear request, FLUSH -> CLEAR once drained, CLEAR -> RUN after the top address
   always_comb begin
      next_state = state;
      case (state)
         RUN:     if (i_clear) next_state = FLUSH;
         FLUSH:   if (flush_done && !s1_valid) next_state = CLEAR;
         CLEAR:   if (o_wr_addr == {ADDR_WIDTH{1'b1}}) next_state = RUN;
         default: next_state = RUN;
      endcase
   end

   // S1 capture of the accepted operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s1_data  <= '0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
      end else begin
         s1_valid <= o_rd_en;
         if (o_rd_en) begin
            s1_addr  <= i_addr;
            s1_data  <= i_data;
            s1_first <= i_first;
            s1_last  <= i_last;
         end
      end
   end

   // old-value select: overwrite, then newest in-flight write, then last-cycle write, then RAM
   always_comb begin
      old_data = i_rd_data;
      if (s1_first)
         old_data = '0;
      else if (s2_valid && (o_wr_addr == s1_addr))
         old_data = o_wr_data;
      else if (s3_valid && (s3_addr == s1_addr))
         old_data = s3_data;
   end

   // per-lane signed add with saturation; one guard bit per lane detects overflow
   always_comb begin
      logic [LANE_WIDTH-1:0] lane_a;
      logic [LANE_WIDTH-1:0] lane_b;
      logic [LANE_WIDTH:0]   lane_w;
      sum_data = '0;
      lane_a   = '0;
      lane_b   = '0;
      lane_w   = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_a = old_data[l*LANE_WIDTH +: LANE_WIDTH];
         lane_b = s1_data[l*LANE_WIDTH +: LANE_WIDTH];
         lane_w = {lane_a[LANE_WIDTH-1], lane_a} + {lane_b[LANE_WIDTH-1], lane_b};
         if (lane_w[LANE_WIDTH] != lane_w[LANE_WIDTH-1])
            sum_data[l*LANE_WIDTH +: LANE_WIDTH] = lane_w[LANE_WIDTH] ?
               {1'b1, {(LANE_WIDTH-1){1'b0}}} : {1'b0, {(LANE_WIDTH-1){1'b1}}};
         else
            sum_data[l*LANE_WIDTH +: LANE_WIDTH] = lane_w[LANE_WIDTH-1:0];
      end
   end

   // S2: registered write port and final-sum output; clear writes take over the port while clearing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid    <= 1'b0;
         o_wr_en     <= 1'b0;
         o_wr_addr   <= '0;
         o_wr_data   <= '0;
         o_out_valid <= 1'b0;
         o_out_addr  <= '0;
         o_out_data  <= '0;
      end else if (next_state == CLEAR) begin
         s2_valid    <= 1'b0;
         o_wr_en     <= 1'b1;
         o_wr_addr   <= clr_addr_next;
         o_wr_data   <= '0;
         o_out_valid <= 1'b0;
      end else begin
         s2_valid    <= s1_valid;
         o_wr_en     <= s1_valid;
         o_wr_addr   <= s1_addr;
         o_wr_data   <= sum_data;
         o_out_valid <= s1_valid & s1_last;
         o_out_addr  <= s1_addr;
         o_out_data  <= sum_data;
      end
   end

   // S3 follows the op write of the previous cycle; emptied on clear so stale sums cannot resurface
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid <= 1'b0;
         s3_addr  <= '0;
         s3_data  <= '0;
      end else if (next_state == CLEAR) begin
         s3_valid <= 1'b0;
      end else begin
         s3_valid <= s2_valid;
         s3_addr  <= o_wr_addr;
         s3_data  <= o_wr_data;
      end
   end

endmodule

// File: tb/tb_accum_rmw_ctrl.sv
// tb/tb_accum_rmw_ctrl.sv - directed self-checking bench for accum_rmw_ctrl with a behavioural BRAM
module tb_accum_rmw_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic [7:0]  i_addr;
   logic [63:0] i_data;
   logic        i_first;
   logic        i_last;
   logic        i_clear;
   logic        o_ready;
   logic        o_rd_en;
   logic [7:0]  o_rd_addr;
   logic [63:0] i_rd_data;
   logic        o_wr_en;
   logic [7:0]  o_wr_addr;
   logic [63:0] o_wr_data;
   logic        o_out_valid;
   logic [7:0]  o_out_addr;
   logic [63:0] o_out_data;
   logic        o_busy;

   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [63:0] pl_data;
   logic [63:0] mem [0:255];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   accum_rmw_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .LANE_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_addr(i_addr), .i_data(i_data),
      .i_first(i_first), .i_last(i_last), .i_clear(i_clear), .o_ready(o_ready),
      .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
      .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
      .o_out_valid(o_out_valid), .o_out_addr(o_out_addr), .o_out_data(o_out_data),
      .o_busy(o_busy)
   );

   // BRAM model: registered read returning old data on a same-edge write; preload port for the bench
   always @(posedge clk) begin
      if (o_rd_en) i_rd_data <= mem[o_rd_addr];
      if (o_wr_en) mem[o_wr_addr] <= o_wr_data;
      else if (pl_en) mem[pl_addr] <= pl_data;
   end

   function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
      return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
   endfunction

   task automatic idle_inputs();
      i_valid = 1'b0;
      i_first = 1'b0;
      i_last  = 1'b0;
      i_clear = 1'b0;
      i_addr  = 8'd0;
      i_data  = 64'd0;
   endtask

   task automatic drive_op(input logic [7:0] a, input logic [63:0] d, input logic f, input logic l);
      i_valid = 1'b1;
      i_addr  = a;
      i_data  = d;
      i_first = f;
      i_last  = l;
   endtask

   task automatic preload(input logic [7:0] a, input logic [63:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pl_en = 1'b0;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({o_ready, o_wr_en, o_out_valid, o_busy, o_rd_en} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 10000", {o_ready, o_wr_en, o_out_valid, o_busy, o_rd_en});
      end
      checks++;
      if ({o_wr_addr, o_wr_data, o_out_addr, o_out_data} !== 144'd0) begin
         failures++;
         $display("FAIL reset_data: got %h expected 0", {o_wr_addr, o_wr_data, o_out_addr, o_out_data});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      preload(8'd5, pk(1, 2, 3, 4));
      drive_op(8'd5, pk(10, 20, 30, 40), 1'b0, 1'b0);
      #1;
      checks++;
      if ({o_rd_en, o_rd_addr} !== {1'b1, 8'd5}) begin
         failures++;
         $display("FAIL single_rd: got %h expected 105", {o_rd_en, o_rd_addr});
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if ({o_wr_en, o_busy} !== 2'b01) begin
         failures++;
         $display("FAIL single_t1: got wr_en/busy %b expected 01", {o_wr_en, o_busy});
      end
      @(negedge clk);
      checks++;
      if ({o_wr_en, o_wr_addr, o_wr_data, o_out_valid} !== {1'b1, 8'd5, pk(11, 22, 33, 44), 1'b0}) begin
         failures++;
         $display("FAIL single_wr: got %b %0d %h %b expected 1 5 %h 0", o_wr_en, o_wr_addr, o_wr_data, o_out_valid, pk(11, 22, 33, 44));
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      preload(8'd7, pk(9, 9, 9, 9));
      for (int c = 0; c < 6; c++) begin
         if (c >= 2) begin
            checks++;
            if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, 8'd7, pk(c - 1, c - 1, c - 1, c - 1)}) begin
               failures++;
               $display("FAIL b2b_wr%0d: got %b %0d %h expected 1 7 %h", c - 2, o_wr_en, o_wr_addr, o_wr_data, pk(c - 1, c - 1, c - 1, c - 1));
            end
         end
         if (c < 4) drive_op(8'd7, pk(1, 1, 1, 1), (c == 0), 1'b0);
         else idle_inputs();
         @(negedge clk);
      end
      for (int c = 0; c < 9; c++) begin
         if (c >= 2 && (c % 2) == 0) begin
            checks++;
            if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, 8'd7, pk(c / 2, c / 2, c / 2, c / 2)}) begin
               failures++;
               $display("FAIL gap_wr%0d: got %b %0d %h expected 1 7 %h", c / 2, o_wr_en, o_wr_addr, o_wr_data, pk(c / 2, c / 2, c / 2, c / 2));
            end
         end else if (c >= 3) begin
            checks++;
            if (o_wr_en !== 1'b0) begin
               failures++;
               $display("FAIL gap_idle%0d: got wr_en %b expected 0", c, o_wr_en);
            end
         end
         if (c < 8 && (c % 2) == 0) drive_op(8'd7, pk(1, 1, 1, 1), (c == 0), 1'b0);
         else idle_inputs();
         @(negedge clk);
      end
      checks++;
      if (mem[7] !== pk(4, 4, 4, 4)) begin
         failures++;
         $display("FAIL gap_mem: got %h expected %h", mem[7], pk(4, 4, 4, 4));
      end
   endtask

   task automatic test_saturation();
      preload(8'd11, pk(32760, -32760, 100, -5));
      preload(8'd12, pk(32767, -32768, 32767, 0));
      drive_op(8'd11, pk(100, -100, -200, 5), 1'b0, 1'b0);
      @(negedge clk);
      drive_op(8'd12, pk(0, -1, -32768, -32768), 1'b0, 1'b0);
      @(negedge clk);
      idle_inputs();
      checks++;
      if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, 8'd11, pk(32767, -32768, -100, 0)}) begin
         failures++;
         $display("FAIL sat_a: got %b %0d %h expected 1 11 %h", o_wr_en, o_wr_addr, o_wr_data, pk(32767, -32768, -100, 0));
      end
      @(negedge clk);
      checks++;
      if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, 8'd12, pk(32767, -32768, -1, -32768)}) begin
         failures++;
         $display("FAIL sat_b: got %b %0d %h expected 1 12 %h", o_wr_en, o_wr_addr, o_wr_data, pk(32767, -32768, -1, -32768));
      end
      @(negedge clk);
   endtask

   task automatic test_last();
      preload(8'd9, pk(2, 2, 2, 2));
      preload(8'd13, pk(99, 99, 99, 99));
      drive_op(8'd9, pk(3, 3, 3, 3), 1'b0, 1'b1);
      @(negedge clk);
      drive_op(8'd13, pk(7, -7, 0, 1), 1'b1, 1'b1);
      @(negedge clk);
      drive_op(8'd9, pk(1, 1, 1, 1), 1'b0, 1'b0);
      checks++;
      if ({o_out_valid, o_out_addr, o_out_data, o_wr_en, o_wr_data} !== {1'b1, 8'd9, pk(5, 5, 5, 5), 1'b1, pk(5, 5, 5, 5)}) begin
         failures++;
         $display("FAIL last_out: got %b %0d %h wr %b %h expected 1 9 %h", o_out_valid, o_out_addr, o_out_data, o_wr_en, o_wr_data, pk(5, 5, 5, 5));
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if ({o_out_valid, o_out_addr, o_out_data, o_wr_data} !== {1'b1, 8'd13, pk(7, -7, 0, 1), pk(7, -7, 0, 1)}) begin
         failures++;
         $display("FAIL first_last: got %b %0d %h wr %h expected 1 13 %h", o_out_valid, o_out_addr, o_out_data, o_wr_data, pk(7, -7, 0, 1));
      end
      @(negedge clk);
      checks++;
      if ({o_out_valid, o_wr_en, o_wr_addr, o_wr_data} !== {1'b0, 1'b1, 8'd9, pk(6, 6, 6, 6)}) begin
         failures++;
         $display("FAIL not_last: got out_valid %b wr %b %0d %h expected 0 1 9 %h", o_out_valid, o_wr_en, o_wr_addr, o_wr_data, pk(6, 6, 6, 6));
      end
      @(negedge clk);
   endtask

   task automatic test_clear();
      int bad;
      int first_bad;
      logic [7:0] a8;
      for (int a = 0; a < 256; a++) begin
         a8 = 8'(a);
         preload(a8, {4{8'hA5, a8}});
      end
      drive_op(8'd3, pk(1, 1, 1, 1), 1'b0, 1'b0);
      i_clear = 1'b1;
      #1;
      checks++;
      if ({o_ready, o_rd_en} !== 2'b11) begin
         failures++;
         $display("FAIL clr_accept: got ready/rd_en %b expected 11", {o_ready, o_rd_en});
      end
      @(negedge clk);
      idle_inputs();
      drive_op(8'd50, pk(1, 1, 1, 1), 1'b0, 1'b0);
      #1;
      checks++;
      if ({o_ready, o_rd_en, o_busy, o_wr_en} !== 4'b0010) begin
         failures++;
         $display("FAIL clr_flush: got ready/rd_en/busy/wr_en %b expected 0010", {o_ready, o_rd_en, o_busy, o_wr_en});
      end
      @(negedge clk);
      checks++;
      if ({o_ready, o_wr_en, o_wr_addr, o_wr_data} !== {1'b0, 1'b1, 8'd3, {4{16'hA504}}}) begin
         failures++;
         $display("FAIL clr_inflight: got %b %b %0d %h expected 0 1 3 %h", o_ready, o_wr_en, o_wr_addr, o_wr_data, {4{16'hA504}});
      end
      bad = 0;
      first_bad = -1;
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         if ({o_wr_en, o_wr_addr, o_wr_data, o_out_valid, o_ready, o_rd_en} !== {1'b1, 8'(k), 64'd0, 3'b000}) begin
            if (bad == 0) first_bad = k;
            bad++;
         end
         if (k == 250) idle_inputs();
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL clr_sequence: got %0d bad cycles (first at index %0d) expected 0", bad, first_bad);
      end
      @(negedge clk);
      checks++;
      if ({o_ready, o_wr_en, o_busy} !== 3'b100) begin
         failures++;
         $display("FAIL clr_done: got ready/wr_en/busy %b expected 100", {o_ready, o_wr_en, o_busy});
      end
      bad = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== 64'd0) bad++;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL clr_mem: got %0d nonzero words expected 0", bad);
      end
      drive_op(8'd200, pk(1, -2, 3, -4), 1'b0, 1'b0);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({o_wr_en, o_wr_addr, o_wr_data} !== {1'b1, 8'd200, pk(1, -2, 3, -4)}) begin
         failures++;
         $display("FAIL clr_after_op: got %b %0d %h expected 1 200 %h", o_wr_en, o_wr_addr, o_wr_data, pk(1, -2, 3, -4));
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_clear();
      int wr_seen;
      preload(8'd99, {4{16'h1111}});
      preload(8'd100, {4{16'h1111}});
      preload(8'd101, {4{16'h1111}});
      i_clear = 1'b1;
      @(negedge clk);
      idle_inputs();
      for (int k = 0; k < 102; k++) @(negedge clk);
      checks++;
      if ({o_wr_en, o_wr_addr} !== {1'b1, 8'd100}) begin
         failures++;
         $display("FAIL midclr_pos: got %b %0d expected 1 100", o_wr_en, o_wr_addr);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({o_ready, o_wr_en, o_wr_addr, o_wr_data, o_out_valid, o_busy, o_rd_en} !== {1'b1, 1'b0, 8'd0, 64'd0, 3'b000}) begin
         failures++;
         $display("FAIL midclr_reset: got ready %b wr %b %0d %h out %b busy %b rd %b expected 1 0 0 0 0 0 0", o_ready, o_wr_en, o_wr_addr, o_wr_data, o_out_valid, o_busy, o_rd_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wr_seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (o_wr_en || !o_ready) wr_seen++;
      end
      checks++;
      if (wr_seen !== 0) begin
         failures++;
         $display("FAIL midclr_resume: got %0d cycles with writes or not ready expected 0", wr_seen);
      end
      checks++;
      if ({mem[99], mem[100], mem[101]} !== {64'd0, {4{16'h1111}}, {4{16'h1111}}}) begin
         failures++;
         $display("FAIL midclr_mem: got %h %h %h expected 0 %h %h", mem[99], mem[100], mem[101], {4{16'h1111}}, {4{16'h1111}});
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_saturation();
      test_last();
      test_clear();
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
